proc_param: RTL and testbench
=============================

# proc_param

Parametrised successor of the 9-bit multicycle bus processor. It is a W-bit datapath with 2^RB general registers, an A/G accumulator pair and a single shared bus. It adds conditional move (mvnz), bitwise AND/XOR and defined reset of all state to the original mv/mvi/add/sub set. It is the execution core driven by the instruction-feed logic over a Run/Done handshake.

## Interface
- W, default 9: data, bus and instruction width. Elaboration error if W < 2*RB+3.
- RB, default 3: register-index width; register count NREG = 2^RB.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  reset, asynchronous, active-low; clock Clock.
- Run  in  1  start request; sampled only in T0.
- DIN  in  W  instruction word in T0; immediate operand in T1 for mvi.
- Done  out  1  one-cycle pulse in the final step of every instruction.
- BusWires  out  W  shared bus value.

## Operation
- Instruction fields:
  - IR[2:0] opcode.
  - X = IR[RB+2:3], destination and first operand.
  - Y = IR[2RB+2:RB+3], source.
  - Bits above 2RB+2 are ignored.
- Opcodes:
  - 000 mv: Rx <= Ry
  - 001 mvi: Rx <= DIN
  - 010 add: Rx <= Rx + Ry
  - 011 sub: Rx <= Rx - Ry
  - 100 mvnz: Rx <= Ry only if G != 0
  - 101 and: Rx <= Rx & Ry
  - 110 xor: Rx <= Rx ^ Ry
  - 111 nop
- FSM states T0, T1, T2, T3, held in a 2-bit state register.
  - T0: if Run, IR <= DIN and go to T1; otherwise stay in T0 and leave IR unchanged.
  - T1, single-step ops (mv, mvi, mvnz, nop): perform the transfer, assert Done, return to T0.
  - T1, ALU ops (add, sub, and, xor): bus = Rx, A <= bus, go to T2.
  - T2: bus = Ry, G <= A op bus, go to T3.
  - T3: bus = G, Rx <= bus, assert Done, go to T0.
- mvnz: G is tested in T1. If G == 0, no register is written but Done still pulses.
- ALU arithmetic is modulo 2^W. Carry and borrow are discarded. sub computes A + ~bus + 1.
- Bus source is one-hot:
  - register Ry or Rx, G, or DIN, as the active step requires;
  - no source selected (T0, nop, mvnz with G == 0) gives BusWires = 0.
- Exactly one register load enable is active per cycle, at most.
- Run is ignored outside T0. Holding Run high runs instructions back-to-back with no idle cycle.
- Reset values, applied immediately and asynchronously:
  - state T0, Done = 0, BusWires = 0;
  - R0..R(NREG-1), A, G, IR all 0.
- Reset mid-instruction aborts the instruction. No partial write completes after release.

## Timing
- mv, mvi, mvnz, nop: 2 cycles (T0, T1). Done is high in T1.
- add, sub, and, xor: 4 cycles (T0..T3). Done is high in T3.
- All register writes occur at the rising edge ending the step that asserts the load enable. The new value is visible on the bus the following cycle.
- Done and BusWires are Moore outputs of state plus IR, except that DIN passes through combinationally onto the bus in the mvi T1 step.
- First fetch is the first rising edge after Resetn deasserts with Run = 1.

## Test plan
- Reset, then check values:
  - Resetn low mid-sim: Done = 0 and BusWires = 0 immediately.
  - After release, mv R1,R0 gives R1 = 0.
- mvi then mv:
  - mvi R0 with DIN = 0x1A5 in T1: Done in cycle 2, R0 = 0x1A5.
  - mv R3,R0: R3 = 0x1A5, BusWires = 0x1A5 during T1.
- add and sub wrap (W = 9):
  - R1 = 3, R2 = 5. sub R1,R2 gives R1 = 510, Done in cycle 4.
  - R1 = 510, R2 = 5. add R1,R2 gives R1 = 3.
- mvnz:
  - After sub leaving G = 0 (R1 = R2 = 7), mvnz R4,R2 leaves R4 unchanged with Done = 1.
  - After add leaving G = 14, mvnz R4,R2 gives R4 = 7.
- and, xor, and back-to-back execution:
  - Run held high with R5 = 0x0F0, R6 = 0x1FF: and R5,R6 gives 0x0F0, then xor R5,R6 gives 0x10F.
  - Exactly 8 cycles elapse with no idle T0 between the instructions.
- Abort and reparametrisation:
  - Resetn pulsed low during T2 of add R1,R2: no write to R1, FSM in T0.
  - Repeat the mvi/add checks at W = 16, RB = 4 with R15 as destination.

Source files
------------

// File: rtl/proc_param.sv
// Parametrised multicycle bus processor: W-bit datapath, 2^RB registers,
// A/G accumulator pair and one shared bus, sequenced by a T0..T3 FSM.
module proc_param #(
  parameter int W  = 9,
  parameter int RB = 3
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [W-1:0] DIN,
  output logic         Done,
  output logic [W-1:0] BusWires
);

  localparam int unsigned NREG = 1 << RB;

  if (W < 2*RB + 3) begin : g_bad_params
    $error("proc_param: W must be at least 2*RB+3");
  end

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  state_t        r_state, w_next;
  logic [W-1:0]  r_regs [NREG];
  logic [W-1:0]  r_A, r_G, r_IR;
  logic [W-1:0]  w_alu;
  logic [2:0]    w_op;
  logic [RB-1:0] w_x, w_y;
  logic          w_sel_rx, w_sel_ry, w_sel_g, w_sel_din;
  logic          w_ld_rx, w_ld_a, w_ld_g, w_ld_ir;
  logic          w_unused_ir;

  assign w_op = r_IR[2:0];
  assign w_x  = r_IR[RB+2:3];
  assign w_y  = r_IR[2*RB+2:RB+3];
  // IR bits above the Y field carry no meaning
  assign w_unused_ir = ^r_IR;

  always_comb begin
    w_next    = r_state;
    w_sel_rx  = 1'b0;
    w_sel_ry  = 1'b0;
    w_sel_g   = 1'b0;
    w_sel_din = 1'b0;
    w_ld_rx   = 1'b0;
    w_ld_a    = 1'b0;
    w_ld_g    = 1'b0;
    w_ld_ir   = 1'b0;
    Done      = 1'b0;
    case (r_state)
      T0: begin
        if (Run) begin
          w_ld_ir = 1'b1;
          w_next  = T1;
        end
      end
      T1: begin
        case (w_op)
          OP_MV: begin
            w_sel_ry = 1'b1;
            w_ld_rx  = 1'b1;
            Done     = 1'b1;
            w_next   = T0;
          end
          OP_MVI: begin
            w_sel_din = 1'b1;
            w_ld_rx   = 1'b1;
            Done      = 1'b1;
            w_next    = T0;
          end
          OP_MVNZ: begin
            if (r_G != '0) begin
              w_sel_ry = 1'b1;
              w_ld_rx  = 1'b1;
            end
            Done   = 1'b1;
            w_next = T0;
          end
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            w_sel_rx = 1'b1;
            w_ld_a   = 1'b1;
            w_next   = T2;
          end
          default: begin
            Done   = 1'b1;
            w_next = T0;
          end
        endcase
      end
      T2: begin
        w_sel_ry = 1'b1;
        w_ld_g   = 1'b1;
        w_next   = T3;
      end
      T3: begin
        w_sel_g = 1'b1;
        w_ld_rx = 1'b1;
        Done    = 1'b1;
        w_next  = T0;
      end
      default: w_next = T0;
    endcase
  end

  always_comb begin
    BusWires = '0;
    if (w_sel_din)     BusWires = DIN;
    else if (w_sel_rx) BusWires = r_regs[w_x];
    else if (w_sel_ry) BusWires = r_regs[w_y];
    else if (w_sel_g)  BusWires = r_G;
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_A + BusWires;
      OP_SUB:  w_alu = r_A + (~BusWires) + W'(1);
      OP_AND:  w_alu = r_A & BusWires;
      OP_XOR:  w_alu = r_A ^ BusWires;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
      r_IR    <= '0;
      r_A     <= '0;
      r_G     <= '0;
      r_regs  <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (w_ld_ir) r_IR <= DIN;
      if (w_ld_a)  r_A  <= BusWires;
      if (w_ld_g)  r_G  <= w_alu;
      if (w_ld_rx) r_regs[w_x] <= BusWires;
    end
  end

endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param: W=9/RB=3 and W=16/RB=4 instances; register
// contents are observed on the bus by issuing mv Rr,Rr.
module tb_proc_param;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run9 = 1'b0;
  logic        run16 = 1'b0;
  logic [15:0] din = '0;
  logic        done9, done16;
  logic [8:0]  bus9;
  logic [15:0] bus16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  proc_param #(.W(9), .RB(3)) u_dut9 (
    .Clock(clk), .Resetn(resetn), .Run(run9), .DIN(din[8:0]),
    .Done(done9), .BusWires(bus9)
  );

  proc_param #(.W(16), .RB(4)) u_dut16 (
    .Clock(clk), .Resetn(resetn), .Run(run16), .DIN(din),
    .Done(done16), .BusWires(bus16)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Upper bits of the 16-bit encoding are deliberately nonzero: they must be ignored
  function automatic logic [15:0] enc(input bit big, input logic [2:0] op, input int x, input int y);
    logic [2:0] x3, y3;
    logic [3:0] x4, y4;
    x3 = 3'(x); y3 = 3'(y);
    x4 = 4'(x); y4 = 4'(y);
    if (big) return {5'b10110, y4, x4, op};
    return {7'b0, y3, x3, op};
  endfunction

  function automatic logic [15:0] cur_bus(input bit big);
    return big ? bus16 : {7'b0, bus9};
  endfunction

  function automatic logic cur_done(input bit big);
    return big ? done16 : done9;
  endfunction

  // Entered at a negedge with the FSM in T0; returns at the negedge of the next T0
  task automatic run_instr(input bit big, input string tag, input logic [15:0] ir,
                           input logic [15:0] imm, input bit hold,
                           output logic [15:0] b1, output logic [15:0] bd, output int cyc);
    if (big) run16 = 1'b1; else run9 = 1'b1;
    din = ir;
    cyc = 1;
    @(posedge clk);
    @(negedge clk);
    cyc = 2;
    if (!hold) begin
      run9  = 1'b0;
      run16 = 1'b0;
    end
    din = imm;
    #1;
    b1 = cur_bus(big);
    while (!cur_done(big) && cyc < 6) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    bd = cur_bus(big);
    check({tag, " done"}, {15'b0, cur_done(big)}, 16'h1);
    @(negedge clk);
  endtask

  task automatic mvi(input bit big, input int x, input logic [15:0] val);
    logic [15:0] b1, bd;
    int cyc;
    run_instr(big, "mvi", enc(big, OP_MVI, x, 0), val, 1'b0, b1, bd, cyc);
  endtask

  task automatic rd(input bit big, input int r, output logic [15:0] val);
    logic [15:0] bd;
    int cyc;
    run_instr(big, "rd", enc(big, OP_MV, r, r), 16'h0, 1'b0, val, bd, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] b1, bd, v;
    int cyc;
    time t0;

    // reset state
    repeat (2) @(negedge clk);
    check("reset done", {15'b0, done9}, 16'h0);
    check("reset bus", {7'b0, bus9}, 16'h0);
    check("reset bus16", bus16, 16'h0);
    resetn = 1'b1;

    run_instr(0, "mv R1,R0", enc(0, OP_MV, 1, 0), 16'h0, 1'b0, b1, bd, cyc);
    check("mv R1,R0 cycles", 16'(cyc), 16'd2);
    check("mv R1,R0 bus", b1, 16'h000);
    rd(0, 1, v);
    check("R1 after reset", v, 16'h000);

    // mvi then mv
    run_instr(0, "mvi R0", enc(0, OP_MVI, 0, 0), 16'h1A5, 1'b0, b1, bd, cyc);
    check("mvi cycles", 16'(cyc), 16'd2);
    check("mvi bus passthrough", b1, 16'h1A5);
    rd(0, 0, v);
    check("R0 after mvi", v, 16'h1A5);
    run_instr(0, "mv R3,R0", enc(0, OP_MV, 3, 0), 16'h0, 1'b0, b1, bd, cyc);
    check("mv R3,R0 bus", b1, 16'h1A5);
    rd(0, 3, v);
    check("R3 after mv", v, 16'h1A5);

    // sub/add wrap at W=9
    mvi(0, 1, 16'd3);
    mvi(0, 2, 16'd5);
    run_instr(0, "sub R1,R2", enc(0, OP_SUB, 1, 2), 16'h0, 1'b0, b1, bd, cyc);
    check("sub cycles", 16'(cyc), 16'd4);
    check("sub T1 bus Rx", b1, 16'd3);
    check("sub T3 bus G", bd, 16'd510);
    rd(0, 1, v);
    check("R1 after sub", v, 16'd510);
    run_instr(0, "add R1,R2", enc(0, OP_ADD, 1, 2), 16'h0, 1'b0, b1, bd, cyc);
    check("add cycles", 16'(cyc), 16'd4);
    rd(0, 1, v);
    check("R1 after add", v, 16'd3);

    // mvnz with G == 0 then G != 0
    mvi(0, 1, 16'd7);
    mvi(0, 2, 16'd7);
    run_instr(0, "sub zero", enc(0, OP_SUB, 1, 2), 16'h0, 1'b0, b1, bd, cyc);
    check("sub to zero G", bd, 16'd0);
    mvi(0, 4, 16'h055);
    run_instr(0, "mvnz G=0", enc(0, OP_MVNZ, 4, 2), 16'h0, 1'b0, b1, bd, cyc);
    check("mvnz G=0 cycles", 16'(cyc), 16'd2);
    check("mvnz G=0 bus", b1, 16'h000);
    rd(0, 4, v);
    check("R4 unchanged", v, 16'h055);
    mvi(0, 1, 16'd7);
    run_instr(0, "add 14", enc(0, OP_ADD, 1, 2), 16'h0, 1'b0, b1, bd, cyc);
    check("add G=14", bd, 16'd14);
    run_instr(0, "mvnz G!=0", enc(0, OP_MVNZ, 4, 2), 16'h0, 1'b0, b1, bd, cyc);
    check("mvnz G!=0 bus", b1, 16'd7);
    rd(0, 4, v);
    check("R4 after mvnz", v, 16'd7);

    // and/xor back to back with Run held high
    mvi(0, 5, 16'h0F0);
    mvi(0, 6, 16'h1FF);
    t0 = $time;
    run_instr(0, "and R5,R6", enc(0, OP_AND, 5, 6), 16'h0, 1'b1, b1, bd, cyc);
    check("and result", bd, 16'h0F0);
    check("and cycles", 16'(cyc), 16'd4);
    run_instr(0, "xor R5,R6", enc(0, OP_XOR, 5, 6), 16'h0, 1'b0, b1, bd, cyc);
    check("xor result", bd, 16'h10F);
    check("back-to-back cycles", 16'(($time - t0) / 10), 16'd8);
    rd(0, 5, v);
    check("R5 after xor", v, 16'h10F);

    run_instr(0, "nop", enc(0, OP_NOP, 2, 3), 16'h0, 1'b0, b1, bd, cyc);
    check("nop cycles", 16'(cyc), 16'd2);
    check("nop bus", b1, 16'h000);

    // abort during T2 of add R1,R2
    mvi(0, 1, 16'd3);
    run9 = 1'b1;
    din = enc(0, OP_ADD, 1, 2);
    @(posedge clk);
    @(negedge clk);
    run9 = 1'b0;
    @(negedge clk);
    #1;
    check("T2 bus Ry", {7'b0, bus9}, 16'd7);
    resetn = 1'b0;
    #1;
    check("abort T2 done", {15'b0, done9}, 16'h0);
    check("abort T2 bus", {7'b0, bus9}, 16'h0);
    @(negedge clk);
    resetn = 1'b1;
    run_instr(0, "post-abort mv", enc(0, OP_MV, 1, 1), 16'h0, 1'b0, b1, bd, cyc);
    check("post-abort T0 cycles", 16'(cyc), 16'd2);
    check("R1 after T2 abort", b1, 16'h000);
    rd(0, 2, v);
    check("R2 cleared by reset", v, 16'h000);

    // abort during T3 (Done high) of add R1,R2
    mvi(0, 1, 16'd3);
    mvi(0, 2, 16'd5);
    run9 = 1'b1;
    din = enc(0, OP_ADD, 1, 2);
    @(posedge clk);
    @(negedge clk);
    run9 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("T3 done", {15'b0, done9}, 16'h1);
    check("T3 bus G", {7'b0, bus9}, 16'd8);
    resetn = 1'b0;
    #1;
    check("abort T3 done", {15'b0, done9}, 16'h0);
    check("abort T3 bus", {7'b0, bus9}, 16'h0);
    @(negedge clk);
    resetn = 1'b1;
    rd(0, 1, v);
    check("R1 after T3 abort", v, 16'h000);

    // W=16, RB=4 with R15 destination
    run_instr(1, "w16 mvi R15", enc(1, OP_MVI, 15, 0), 16'hBEEF, 1'b0, b1, bd, cyc);
    check("w16 mvi bus", b1, 16'hBEEF);
    check("w16 mvi cycles", 16'(cyc), 16'd2);
    rd(1, 15, v);
    check("w16 R15 after mvi", v, 16'hBEEF);
    mvi(1, 14, 16'h4112);
    run_instr(1, "w16 add", enc(1, OP_ADD, 15, 14), 16'h0, 1'b0, b1, bd, cyc);
    check("w16 add cycles", 16'(cyc), 16'd4);
    check("w16 add wrap", bd, 16'h0001);
    rd(1, 15, v);
    check("w16 R15 after add", v, 16'h0001);
    run_instr(1, "w16 sub", enc(1, OP_SUB, 15, 14), 16'h0, 1'b0, b1, bd, cyc);
    check("w16 sub wrap", bd, 16'hBEEF);
    rd(1, 15, v);
    check("w16 R15 after sub", v, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
